// File: rtl/vga_fb_arbiter_if.sv
// CPU-side access port of the frame-buffer arbiter.
// The CPU side is the master, the arbiter is the slave.
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_vblank_only;
    logic              cpu_ack;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_vblank_only,
        input  cpu_ack, cpu_rvalid, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_vblank_only,
        output cpu_ack, cpu_rvalid, cpu_rdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: one single-port synchronous RAM shared between VGA
// scan-out (absolute priority, one fetch per 4 display pixels) and a CPU
// read/write port. Stored pixels are RGB332, replicated 4x4 on the display.
module vga_fb_arbiter #(
    parameter int FB_W   = 160,
    parameter int FB_H   = 120,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic              clk_25,
    input  logic              rst,
    input  logic [9:0]        vga_x,
    input  logic [9:0]        vga_y,
    input  logic              vga_active,
    input  logic              disp_done,
    vga_fb_arbiter_if.slave   cpu,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        pix_r,
    output logic [7:0]        pix_g,
    output logic [7:0]        pix_b,
    output logic [15:0]       frame_count
);
    localparam logic [ADDR_W:0] FB_SIZE = (ADDR_W+1)'(FB_W * FB_H);

    typedef enum logic {IDLE, RDATA} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_d;
    logic              ack_d, rvalid_d;
    logic [DATA_W-1:0] rdata_d;
    logic              rd_oor_q;
    logic              fetch_d1_q, active_d1_q, active_d2_q;
    logic [DATA_W-1:0] hold_q;
    logic              dd_q, in_vblank_q;
    logic [15:0]       frame_count_q;

    // Fetch slot: first display pixel of every 4-wide group.
    logic              fetch;
    logic [ADDR_W-1:0] vy, vx, row_base, fetch_addr;
    logic              in_range, dd_rise;
    logic              unused_bits;

    assign fetch       = vga_active && (vga_x[1:0] == 2'b00);
    assign vy          = ADDR_W'(vga_y[9:2]);
    assign vx          = ADDR_W'(vga_x[9:2]);
    assign unused_bits = ^vga_y[1:0];

    // Row base address; the 160-wide case avoids a multiplier.
    if (FB_W == 160) begin : g_mul160
        assign row_base = (vy << 7) + (vy << 5);
    end else begin : g_mul
        assign row_base = vy * ADDR_W'(FB_W);
    end

    assign fetch_addr = row_base + vx;
    assign in_range   = {1'b0, cpu.cpu_addr} < FB_SIZE;
    assign dd_rise    = disp_done && !dd_q;

    // Bus mux and CPU FSM: scan-out first, CPU only in non-fetch IDLE cycles.
    always_comb begin
        state_d     = state_q;
        ack_d       = 1'b0;
        rvalid_d    = 1'b0;
        rdata_d     = '0;
        mem_addr_d  = fetch ? fetch_addr : mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fetch && cpu.cpu_req && (!cpu.cpu_vblank_only || in_vblank_q)) begin
                    ack_d       = 1'b1;
                    mem_addr_d  = cpu.cpu_addr;
                    mem_wdata_d = cpu.cpu_wdata;
                    mem_we_d    = cpu.cpu_we && in_range;
                    if (!cpu.cpu_we) state_d = RDATA;
                end
            end
            RDATA: begin
                rvalid_d = 1'b1;
                rdata_d  = rd_oor_q ? '0 : mem_rdata;
                state_d  = IDLE;
            end
        endcase
        // Outputs are forced low for the whole time reset is held.
        if (!rst) begin
            ack_d       = 1'b0;
            rvalid_d    = 1'b0;
            rdata_d     = '0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            mem_we_d    = 1'b0;
        end
    end

    // FSM state, last bus values and the out-of-range flag of a pending read.
    always_ff @(posedge clk_25 or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_oor_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if (ack_d && !cpu.cpu_we) rd_oor_q <= !in_range;
        end
    end

    // Two-stage pixel pipeline: RAM latency then the hold register.
    always_ff @(posedge clk_25 or negedge rst) begin
        if (!rst) begin
            fetch_d1_q  <= 1'b0;
            active_d1_q <= 1'b0;
            active_d2_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            fetch_d1_q  <= fetch;
            active_d1_q <= vga_active;
            active_d2_q <= active_d1_q;
            if (fetch_d1_q) hold_q <= mem_rdata;
        end
    end

    // Vertical-blank window and frame counter, both keyed off disp_done's rise.
    always_ff @(posedge clk_25 or negedge rst) begin
        if (!rst) begin
            dd_q          <= 1'b0;
            in_vblank_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            dd_q <= disp_done;
            if (dd_rise) begin
                in_vblank_q   <= 1'b1;
                frame_count_q <= frame_count_q + 16'd1;
            end else if (vga_active) begin
                in_vblank_q   <= 1'b0;
            end
        end
    end

    assign mem_addr       = mem_addr_d;
    assign mem_wdata      = mem_wdata_d;
    assign mem_we         = mem_we_d;
    assign cpu.cpu_ack    = ack_d;
    assign cpu.cpu_rvalid = rvalid_d;
    assign cpu.cpu_rdata  = rdata_d;
    assign frame_count    = frame_count_q;

    // RGB332 expanded to 8 bits per channel by bit replication.
    assign pix_r = active_d2_q ? {hold_q[7:5], hold_q[7:5], hold_q[7:6]} : 8'd0;
    assign pix_g = active_d2_q ? {hold_q[4:2], hold_q[4:2], hold_q[4:3]} : 8'd0;
    assign pix_b = active_d2_q ? {4{hold_q[1:0]}} : 8'd0;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter with a behavioural RAM and a
// reference model of scan-out colours, CPU grants, vblank and frame count.
module tb_vga_fb_arbiter;
    logic        clk_25 = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  vga_x = '0, vga_y = '0;
    logic        vga_active = 1'b0, disp_done = 1'b0;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_we;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic [15:0] frame_count;

    vga_fb_arbiter_if #(.ADDR_W(15), .DATA_W(8)) cpu_if ();

    vga_fb_arbiter dut (
        .clk_25(clk_25), .rst(rst),
        .vga_x(vga_x), .vga_y(vga_y), .vga_active(vga_active), .disp_done(disp_done),
        .cpu(cpu_if),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .frame_count(frame_count)
    );

    always #5 clk_25 = ~clk_25;

    // Single-port synchronous RAM, one-cycle read latency.
    bit [7:0] mem [0:32767];
    always @(posedge clk_25) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int checks = 0;
    int errors = 0;

    // Reference state.
    bit [7:0]   ref_fb [0:32767];
    logic [8:0] pq [$];
    logic [7:0] last_pix;
    logic       vb_m, dd_m, rd_m, drop_req, keep_once;
    logic [7:0] rd_exp;
    logic [15:0] fc_m;
    logic       pend, p_we, p_vbo;
    logic [14:0] p_addr;
    logic [7:0] p_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_rgb(input logic [8:0] e);
        logic [7:0] r, g, b;
        int r3, g3, b2;
        if (!e[8]) return 24'd0;
        r3 = int'(e[7:5]); g3 = int'(e[4:2]); b2 = int'(e[1:0]);
        r = 8'((r3 << 5) | (r3 << 2) | (r3 >> 1));
        g = 8'((g3 << 5) | (g3 << 2) | (g3 >> 1));
        b = 8'(b2 * 85);
        return {r, g, b};
    endfunction

    task automatic model_init();
        pq.delete();
        pq.push_back(9'd0);
        pq.push_back(9'd0);
        last_pix = 8'd0; vb_m = 1'b0; dd_m = 1'b0; rd_m = 1'b0;
        drop_req = 1'b0; keep_once = 1'b0; fc_m = 16'd0; pend = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [14:0] a, input logic [7:0] d, input logic vbo);
        pend = 1'b1; p_we = we; p_addr = a; p_data = d; p_vbo = vbo;
    endtask

    // One clock of stimulus; inputs change on the falling edge, checks 2ns later.
    task automatic step(input logic [9:0] x, input logic [9:0] y, input logic act, input logic dd);
        logic fetch_m, exp_ack, inr;
        logic [8:0] e;
        logic [23:0] rgb;
        int fa;
        @(negedge clk_25);
        vga_x = x; vga_y = y; vga_active = act; disp_done = dd;
        if (drop_req) begin cpu_if.cpu_req = 1'b0; drop_req = 1'b0; end
        if (pend) begin
            cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = p_we; cpu_if.cpu_addr = p_addr;
            cpu_if.cpu_wdata = p_data; cpu_if.cpu_vblank_only = p_vbo; pend = 1'b0;
        end
        #2;
        fetch_m = act && (x % 4 == 0);
        fa = (int'(y) / 4) * 160 + int'(x) / 4;
        exp_ack = cpu_if.cpu_req && !rd_m && !fetch_m && (!cpu_if.cpu_vblank_only || vb_m);
        chk("cpu_ack", 32'(cpu_if.cpu_ack), 32'(exp_ack));
        if (fetch_m) begin
            chk("fetch_addr", 32'(mem_addr), 32'(fa));
            chk("fetch_we", 32'(mem_we), 32'(1'b0));
        end
        chk("cpu_rvalid", 32'(cpu_if.cpu_rvalid), 32'(rd_m));
        if (rd_m) chk("cpu_rdata", 32'(cpu_if.cpu_rdata), 32'(rd_exp));
        rd_m = 1'b0;
        if (exp_ack) begin
            inr = int'(cpu_if.cpu_addr) < 19200;
            chk("grant_we", 32'(mem_we), 32'(cpu_if.cpu_we && inr));
            chk("grant_addr", 32'(mem_addr), 32'(cpu_if.cpu_addr));
            if (cpu_if.cpu_we) begin
                chk("grant_wdata", 32'(mem_wdata), 32'(cpu_if.cpu_wdata));
                if (inr) ref_fb[cpu_if.cpu_addr] = cpu_if.cpu_wdata;
            end else begin
                rd_m = 1'b1;
                rd_exp = inr ? ref_fb[cpu_if.cpu_addr] : 8'd0;
            end
            if (keep_once) keep_once = 1'b0;
            else drop_req = 1'b1;
        end
        chk("frame_count", 32'(frame_count), 32'(fc_m));
        if (fetch_m) last_pix = ref_fb[fa];
        pq.push_back({act, last_pix});
        e = pq.pop_front();
        rgb = exp_rgb(e);
        chk("pix_r", 32'(pix_r), 32'(rgb[23:16]));
        chk("pix_g", 32'(pix_g), 32'(rgb[15:8]));
        chk("pix_b", 32'(pix_b), 32'(rgb[7:0]));
        if (dd && !dd_m) begin vb_m = 1'b1; fc_m = fc_m + 16'd1; end
        else if (act) vb_m = 1'b0;
        dd_m = dd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(10'd0, 10'd0, 1'b0, 1'b0);
    endtask

    // Reset asserted mid-cycle during an active fetch slot.
    task automatic do_reset(input logic [9:0] x, input logic [9:0] y);
        @(negedge clk_25);
        vga_x = x; vga_y = y; vga_active = 1'b1; rst = 1'b0;
        #1;
        chk("rst_ack", 32'(cpu_if.cpu_ack), 32'd0);
        chk("rst_rvalid", 32'(cpu_if.cpu_rvalid), 32'd0);
        chk("rst_rdata", 32'(cpu_if.cpu_rdata), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_pix", 32'({pix_r, pix_g, pix_b}), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        cpu_if.cpu_req = 1'b0;
        @(negedge clk_25);
        vga_active = 1'b0; disp_done = 1'b0;
        @(negedge clk_25);
        rst = 1'b1;
        model_init();
    endtask

    initial begin
        int mism;
        logic [9:0] xs, ys;
        int len;
        cpu_if.cpu_req = 1'b0; cpu_if.cpu_we = 1'b0; cpu_if.cpu_addr = '0;
        cpu_if.cpu_wdata = '0; cpu_if.cpu_vblank_only = 1'b0;
        model_init();
        do_reset(10'd0, 10'd0);

        // Preload two pixels and scan the start of line 0.
        issue(1'b1, 15'd0, 8'hE0, 1'b0); idle(3);
        issue(1'b1, 15'd1, 8'h1C, 1'b0); idle(3);
        for (int x = 0; x < 8; x++) step(10'(x), 10'd0, 1'b1, 1'b0);
        idle(3);

        // Write to the last pixel presented in a fetch slot: waits one cycle.
        issue(1'b1, 15'd19199, 8'h03, 1'b0);
        for (int x = 0; x < 4; x++) step(10'(x), 10'd0, 1'b1, 1'b0);
        idle(2);
        for (int x = 636; x < 640; x++) step(10'(x), 10'd479, 1'b1, 1'b0);
        idle(3);

        // Read-back with the request held through RDATA.
        issue(1'b1, 15'd160, 8'hA5, 1'b0); idle(3);
        keep_once = 1'b1;
        issue(1'b0, 15'd160, 8'h00, 1'b0); idle(5);

        // Vblank-only write raised mid-frame, then a line-long disp_done.
        for (int x = 0; x < 40; x++) step(10'(x), 10'd10, 1'b1, 1'b0);
        issue(1'b1, 15'd500, 8'h5A, 1'b1);
        for (int x = 40; x < 120; x++) step(10'(x), 10'd10, 1'b1, 1'b0);
        for (int i = 0; i < 800; i++) step(10'd0, 10'd0, 1'b0, 1'b1);
        idle(3);
        for (int x = 0; x < 8; x++) step(10'(x), 10'd12, 1'b1, 1'b0);
        idle(2);

        // Out-of-range write and read.
        issue(1'b1, 15'd19200, 8'h77, 1'b0); idle(3);
        issue(1'b0, 15'd19200, 8'h00, 1'b0); idle(4);

        // Random scan segments with concurrent CPU traffic.
        for (int it = 0; it < 300; it++) begin
            if (!cpu_if.cpu_req && !pend && ($urandom_range(0, 1) == 1))
                issue(1'($urandom_range(0, 1)), 15'($urandom_range(0, 19299)),
                      8'($urandom), 1'b0);
            ys  = 10'($urandom_range(0, 479));
            xs  = 10'(4 * $urandom_range(0, 150));
            len = $urandom_range(4, 40);
            for (int k = 0; k < len; k++) step(xs + 10'(k), ys, 1'b1, 1'b0);
            for (int k = 0; k < int'($urandom_range(1, 4)); k++)
                step(10'd0, 10'd0, 1'b0, 1'($urandom_range(0, 1)));
        end
        idle(4);

        mism = 0;
        for (int i = 0; i < 32768; i++) if (mem[i] !== ref_fb[i]) mism++;
        chk("ram_contents", 32'(mism), 32'd0);

        // Reset while a read is in its data cycle.
        issue(1'b0, 15'd160, 8'h00, 1'b0);
        step(10'd2, 10'd0, 1'b0, 1'b0);
        do_reset(10'd4, 10'd8);
        idle(4);
        for (int x = 0; x < 4; x++) step(10'(x), 10'd0, 1'b1, 1'b0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous frame-buffer RAM between the VGA scan-out path and a CPU-side read/write port.
- Scan-out has absolute priority. The frame buffer is 160x120, RGB332, and each stored pixel is replicated 4x4 onto the 640x480 display.
- Sits between vga_driver (x, y, active, disp_done) and the frame-buffer RAM. Drives vga_driver's r/g/b inputs.

Parameters:
- FB_W, 160, frame-buffer width in stored pixels
- FB_H, 120, frame-buffer height in stored pixels
- ADDR_W, 15, RAM address width; must satisfy 2^ADDR_W >= FB_W*FB_H
- DATA_W, 8, RAM word width, RGB332 packed as {r[2:0], g[2:0], b[1:0]}

Ports:
- clk_25 in 1: pixel clock, rising edge
- rst in 1: asynchronous, active-low reset
- vga_x in 10: current display column from the driver
- vga_y in 10: current display row from the driver
- vga_active in 1: high when the current pixel is in the visible area
- disp_done in 1: end-of-frame level from the driver; only its rising edge is used
- cpu_req in 1: CPU request, held high until cpu_ack
- cpu_we in 1: 1 = write, 0 = read; stable while cpu_req is high
- cpu_addr in ADDR_W: linear frame-buffer address, y*FB_W + x
- cpu_wdata in DATA_W: write data
- cpu_vblank_only in 1: when 1, CPU accesses are granted only during vertical blank
- cpu_ack out 1: one-cycle grant pulse
- cpu_rvalid out 1: one-cycle pulse, asserted the cycle after a read ack
- cpu_rdata out DATA_W: read data, valid while cpu_rvalid is high
- mem_addr out ADDR_W: RAM address
- mem_wdata out DATA_W: RAM write data
- mem_we out 1: RAM write enable
- mem_rdata in DATA_W: RAM read data, one-cycle latency
- pix_r out 8: expanded red to driver
- pix_g out 8: expanded green to driver
- pix_b out 8: expanded blue to driver
- frame_count out 16: number of completed frames, wraps

Behaviour:
- Reset values:
  - All outputs 0, pixel hold register 0, all pipeline flags 0.
  - FSM returns to IDLE; in_vblank = 0; frame_count = 0.
  - Any in-flight CPU access is dropped with no ack and no rvalid.
- Fetch slot: a cycle where vga_active = 1 and vga_x[1:0] = 0.
  - mem_addr = (vga_y>>2)*FB_W + (vga_x>>2); mem_we = 0.
  - Compute the product as (vy<<7)+(vy<<5) at ADDR_W bits for FB_W = 160; a generic multiply is used otherwise.
- Pixel pipeline:
  - fetch_d1 and active_d1/active_d2 are registered copies of the fetch-slot flag and vga_active.
  - When fetch_d1 = 1, hold <= mem_rdata.
  - pix_* = expand(hold) when active_d2 = 1, else 0.
  - Latency is exactly 2 clocks from (x, y) to its colour; the top level delays vga_hs/vga_vs by 2 to compensate.
- Colour expansion by bit replication:
  - r8 = {r3, r3, r3[2:1]}
  - g8 = {g3, g3, g3[2:1]}
  - b8 = {b2, b2, b2, b2}
- in_vblank:
  - Set on the rising edge of disp_done (registered edge detect).
  - Cleared on the first cycle with vga_active = 1.
- frame_count increments by 1 on each disp_done rising edge.
- CPU grant condition: cpu_req = 1, the FSM is in IDLE, the cycle is not a fetch slot, and (cpu_vblank_only = 0 or in_vblank = 1).
- FSM IDLE:
  - On grant: mem_addr = cpu_addr, mem_wdata = cpu_wdata, mem_we = cpu_we AND in-range; cpu_ack = 1 this cycle.
  - Read grant goes to RDATA; write grant stays in IDLE.
- FSM RDATA:
  - cpu_rvalid = 1; cpu_rdata = mem_rdata, or 0 if the address was out of range; go to IDLE.
  - No grant is possible in RDATA, so back-to-back reads are separated by at least one cycle.
- Out-of-range cpu_addr (>= FB_W*FB_H): the access is still acked; writes are suppressed and reads return 0.
- Collision: a CPU request in a fetch slot waits. Scan-out is never delayed or skipped.
- Idle bus (no fetch, no grant): mem_we = 0 and mem_addr holds its last value.
- cpu_req must not drop before cpu_ack; if it does, no access occurs.

Test Plan:
- Reset, then preload RAM[0] = 8'hE0, RAM[1] = 8'h1C; scan line 0 with x = 0..7 → pix_r = 8'hFF for x 0..3 and pix_g = 8'hFF for x 4..7, each exactly 2 clocks after x is presented; pix_* = 0 while active is low.
- CPU write addr 19199, data 8'h03 with cpu_vblank_only = 0, presented in a fetch slot → no ack in that cycle; ack on the next non-fetch cycle with mem_we = 1; scanning (639, 479) later shows pix_b = 8'hFF.
- CPU read addr 160 with RAM = 8'hA5 → cpu_ack in the grant cycle, then cpu_rvalid with cpu_rdata = 8'hA5 one cycle later; no second ack before IDLE.
- cpu_vblank_only = 1, request raised mid-frame → no ack until after the disp_done rising edge; ack within 1 cycle of the edge; frame_count increments by exactly 1 even though disp_done stays high for a full line.
- Write addr 19200 (out of range) → ack given, mem_we stays 0; a read of 19200 returns rvalid with data 0.
- Assert rst low during RDATA and mid-line → all outputs 0 immediately; after release, no stale rvalid and frame_count = 0.
